// File: rtl/bpe_ntt_butterfly.sv
// Radix-2 modular NTT butterfly PE (Cooley-Tukey; Gentleman-Sande selectable per triple when BPE_DIF_EN is defined).
// Latency: A' is presented 4 cycles after the triple is accepted, and B' follows on the next accepted beat.
// Backpressure: the whole pipeline advances only while the serializer is empty or its B' beat is leaving; bpe_rdy mirrors that.
module bpe_ntt_butterfly #(
   parameter int          pDATA_WIDTH = 128,
   parameter logic [63:0] pQ          = 64'hFFFFFFFF00000001
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bpe_vld,
   output logic                   bpe_rdy,
   input  logic [pDATA_WIDTH-1:0] bpe_a,
   input  logic [pDATA_WIDTH-1:0] bpe_b,
   input  logic [pDATA_WIDTH-1:0] bpe_c,
`ifdef BPE_DIF_EN
   input  logic                   dif,
`endif
   output logic                   iop_vld,
   input  logic                   iop_rdy,
   output logic [pDATA_WIDTH-1:0] iop_dat,
   output logic                   iop_sel,
   output logic                   busy
);

   // Barrett constant floor(2^128 / Q); with p < Q^2 the quotient estimate is short by at most one.
   localparam logic [128:0] MU = {1'b1, 128'd0} / {65'd0, pQ};

   typedef enum logic [1:0] {SER_EMPTY, SER_SEND_A, SER_SEND_B} ser_state_t;

   ser_state_t  ser_state;
   logic        adv;
   logic        in_dif;

   logic        s1_vld, s2_vld, s3_vld;
   logic [63:0] s1_a, s1_b, s1_c;
   logic        s1_dif, s2_dif, s3_dif;
   logic [127:0] s2_p;
   logic [63:0] s2_x;      // a (CT) or (a+b) mod Q (GS)
   logic [63:0] s3_t;
   logic [63:0] s3_x;
   logic [63:0] ser_b;

   // Upper lanes of the inputs carry no data.
   logic        upper_unused;
   assign upper_unused = ^{bpe_a[pDATA_WIDTH-1:64], bpe_b[pDATA_WIDTH-1:64], bpe_c[pDATA_WIDTH-1:64]};

`ifdef BPE_DIF_EN
   assign in_dif = dif;
`else
   assign in_dif = 1'b0;
`endif

   // Everything moves together; a stalled B' beat freezes the pipe so pairs never interleave.
   assign adv     = (ser_state == SER_EMPTY) | ((ser_state == SER_SEND_B) & iop_rdy);
   assign bpe_rdy = adv & ~rst;
   assign busy    = s1_vld | s2_vld | s3_vld | (ser_state != SER_EMPTY);

   // S1 -> S2: GS pre-add/pre-subtract, then the full 128-bit product.
   logic [64:0]  s1_sum65;
   logic [63:0]  s1_sum, s1_diff, mul_x;
   logic [127:0] prod;
   assign s1_sum65 = {1'b0, s1_a} + {1'b0, s1_b};
   assign s1_sum   = (s1_sum65 >= {1'b0, pQ}) ? 64'(s1_sum65 - {1'b0, pQ}) : s1_sum65[63:0];
   assign s1_diff  = (s1_a >= s1_b) ? (s1_a - s1_b) : (s1_a - s1_b + pQ);
   assign mul_x    = s1_dif ? s1_diff : s1_b;
   assign prod     = {64'd0, mul_x} * {64'd0, s1_c};

   // S2 -> S3: Barrett reduction; remainder lands in [0, 2Q) so one correction suffices.
   logic [63:0] bar_q;
   logic [65:0] bar_r;
   logic [63:0] red_t;
   assign bar_q = 64'(({129'd0, s2_p} * {128'd0, MU}) >> 128);
   assign bar_r = s2_p[65:0] - ({2'b00, bar_q} * {2'b00, pQ});
   assign red_t = (bar_r >= {2'b00, pQ}) ? 64'(bar_r - {2'b00, pQ}) : bar_r[63:0];

   // S3 -> SER: CT post-add/post-subtract; GS results are already final.
   logic [64:0] ct_sum65;
   logic [63:0] ct_a, ct_b, res_a, res_b;
   assign ct_sum65 = {1'b0, s3_x} + {1'b0, s3_t};
   assign ct_a     = (ct_sum65 >= {1'b0, pQ}) ? 64'(ct_sum65 - {1'b0, pQ}) : ct_sum65[63:0];
   assign ct_b     = (s3_x >= s3_t) ? (s3_x - s3_t) : (s3_x - s3_t + pQ);
   assign res_a    = s3_dif ? s3_x : ct_a;
   assign res_b    = s3_dif ? s3_t : ct_b;

   // Stage valid bits: cleared on reset, shifted (bubbles included) on every advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         s3_vld <= 1'b0;
      end else if (adv) begin
         s1_vld <= bpe_vld;
         s2_vld <= s1_vld;
         s3_vld <= s2_vld;
      end
   end

   // Stage payloads: qualified by the valid bits, so no reset needed.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_a   <= bpe_a[63:0];
         s1_b   <= bpe_b[63:0];
         s1_c   <= bpe_c[63:0];
         s1_dif <= in_dif;
         s2_p   <= prod;
         s2_x   <= s1_dif ? s1_sum : s1_a;
         s2_dif <= s1_dif;
         s3_t   <= red_t;
         s3_x   <= s2_x;
         s3_dif <= s2_dif;
      end
   end

   // Serializer: loads {A',B'} from S3, emits A' then B', reloads directly on the B' handoff.
   always_ff @(posedge clk) begin
      if (rst) begin
         ser_state <= SER_EMPTY;
         iop_vld   <= 1'b0;
         iop_sel   <= 1'b0;
         iop_dat   <= '0;
         ser_b     <= '0;
      end else begin
         case (ser_state)
            SER_SEND_A: begin
               if (iop_rdy) begin
                  ser_state <= SER_SEND_B;
                  iop_sel   <= 1'b1;
                  iop_dat   <= {{(pDATA_WIDTH-64){1'b0}}, ser_b};
               end
            end
            default: begin
               if (adv) begin
                  if (s3_vld) begin
                     ser_state <= SER_SEND_A;
                     iop_vld   <= 1'b1;
                     iop_sel   <= 1'b0;
                     iop_dat   <= {{(pDATA_WIDTH-64){1'b0}}, res_a};
                     ser_b     <= res_b;
                  end else begin
                     ser_state <= SER_EMPTY;
                     iop_vld   <= 1'b0;
                     iop_sel   <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bpe_ntt_butterfly.sv
// Testbench for bpe_ntt_butterfly: directed and random triples against a modular-arithmetic model.
// Expected beats are queued at acceptance and popped by a monitor on each output transfer.
// iop_rdy is driven randomly, always high, or manually depending on the phase.
module tb_bpe_ntt_butterfly;

   localparam logic [63:0] Q = 64'hFFFFFFFF00000001;

   typedef struct packed {
      logic         sel;
      logic [127:0] dat;
   } beat_t;

   logic         clk;
   logic         rst;
   logic         bpe_vld;
   logic         bpe_rdy;
   logic [127:0] bpe_a, bpe_b, bpe_c;
   logic         iop_vld;
   logic         iop_rdy;
   logic [127:0] iop_dat;
   logic         iop_sel;
   logic         busy;
`ifdef BPE_DIF_EN
   logic         dif;
`endif

   bpe_ntt_butterfly dut (
      .clk     (clk),
      .rst     (rst),
      .bpe_vld (bpe_vld),
      .bpe_rdy (bpe_rdy),
      .bpe_a   (bpe_a),
      .bpe_b   (bpe_b),
      .bpe_c   (bpe_c),
`ifdef BPE_DIF_EN
      .dif     (dif),
`endif
      .iop_vld (iop_vld),
      .iop_rdy (iop_rdy),
      .iop_dat (iop_dat),
      .iop_sel (iop_sel),
      .busy    (busy)
   );

   beat_t        sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           duty = 100;      // <0: manual iop_rdy
   logic         rdy_manual = 1'b1;
   bit           in_stream = 0;
   int           stream_beats = 0;
   int           stream_first = 0;
   int           stream_last = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready generator
   initial begin
      iop_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (duty < 0) iop_rdy = rdy_manual;
         else          iop_rdy = ($urandom_range(0, 99) < duty);
      end
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y);
      logic [127:0] p;
      p = {64'd0, x} * {64'd0, y};
      return 64'(p % {64'd0, Q});
   endfunction

   function automatic logic [63:0] addmod(input logic [63:0] x, input logic [63:0] y);
      logic [64:0] s;
      s = {1'b0, x} + {1'b0, y};
      return 64'(s % {1'b0, Q});
   endfunction

   function automatic logic [63:0] submod(input logic [63:0] x, input logic [63:0] y);
      logic [64:0] s;
      s = {1'b0, x} + {1'b0, Q} - {1'b0, y};
      return 64'(s % {1'b0, Q});
   endfunction

   function automatic logic [63:0] rand_coef();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if (v >= Q) v = v - Q;
      return v;
   endfunction

   task automatic push_pair(input logic [63:0] ea, input logic [63:0] eb);
      sb.push_back({1'b0, 64'd0, ea});
      sb.push_back({1'b1, 64'd0, eb});
   endtask

   task automatic push_model(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic d);
      if (d) push_pair(addmod(a, b), mulmod(submod(a, b), c));
      else   push_pair(addmod(a, mulmod(b, c)), submod(a, mulmod(b, c)));
   endtask

   // Offer one triple until accepted; expected = 0 pushes the model result, otherwise (ea, eb).
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic d,
                       input bit use_const, input logic [63:0] ea, input logic [63:0] eb);
      bit fire;
      int t;
      fire = 0;
      t = 0;
      bpe_a   = {$urandom, $urandom, a};
      bpe_b   = {$urandom, $urandom, b};
      bpe_c   = {$urandom, $urandom, c};
`ifdef BPE_DIF_EN
      dif     = d;
`endif
      bpe_vld = 1'b1;
      while (!fire) begin
         @(negedge clk);
         fire = bpe_rdy;
         if (fire) begin
            if (use_const) push_pair(ea, eb);
            else           push_model(a, b, c, d);
         end
         @(posedge clk);
         t++;
         if (!fire && t > 2000) begin
            errors++;
            $display("FAIL send_timeout: bpe_rdy stayed 0 for %0d cycles, required acceptance", t);
            break;
         end
      end
      #1;
      bpe_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats still expected, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit           prev_stall = 0;
   logic [127:0] prev_dat;
   logic         prev_sel;

   always @(negedge clk) begin
      beat_t exp;
      if (!rst) begin
         if (prev_stall) begin
            checks++;
            if (iop_vld !== 1'b1 || iop_dat !== prev_dat || iop_sel !== prev_sel) begin
               errors++;
               $display("FAIL stall_hold: vld=%0b sel=%0b dat=%h, required vld=1 sel=%0b dat=%h",
                        iop_vld, iop_sel, iop_dat, prev_sel, prev_dat);
            end
         end
         checks++;
         if (bpe_rdy !== (!iop_vld || (iop_sel && iop_rdy))) begin
            errors++;
            $display("FAIL bpe_rdy_rule: bpe_rdy=%0b with vld=%0b sel=%0b rdy=%0b, required %0b",
                     bpe_rdy, iop_vld, iop_sel, iop_rdy, (!iop_vld || (iop_sel && iop_rdy)));
         end
         if (iop_vld && iop_rdy) begin
            if (in_stream) begin
               if (stream_beats == 0) stream_first = cyc;
               stream_last = cyc;
               stream_beats++;
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: sel=%0b dat=%h, required no beat", iop_sel, iop_dat);
            end else begin
               exp = sb.pop_front();
               if ({iop_sel, iop_dat} !== exp) begin
                  errors++;
                  $display("FAIL beat: sel=%0b dat=%h, required sel=%0b dat=%h",
                           iop_sel, iop_dat, exp.sel, exp.dat);
               end
            end
         end
         prev_stall = iop_vld && !iop_rdy;
         prev_dat   = iop_dat;
         prev_sel   = iop_sel;
      end else begin
         prev_stall = 0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      rst     = 1'b1;
      bpe_vld = 1'b0;
      bpe_a   = '0;
      bpe_b   = '0;
      bpe_c   = '0;
`ifdef BPE_DIF_EN
      dif     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bpe_rdy !== 1'b0 || iop_vld !== 1'b0 || iop_sel !== 1'b0 || iop_dat !== 128'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%0b vld=%0b sel=%0b dat=%h busy=%0b, required all 0",
                  bpe_rdy, iop_vld, iop_sel, iop_dat, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bpe_rdy !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: bpe_rdy=%0b busy=%0b, required 1 and 0", bpe_rdy, busy);
      end
      @(posedge clk);
      #1;

      // Basic + latency
      duty = 100;
      send(64'd5, 64'd3, 64'd7, 1'b0, 1, 64'd26, 64'hFFFFFFFEFFFFFFF1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (iop_vld !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL latency_early: vld=%0b busy=%0b in cycle n+3, required vld=0 busy=1", iop_vld, busy);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (iop_vld !== 1'b1 || iop_sel !== 1'b0 || iop_dat !== 128'd26) begin
         errors++;
         $display("FAIL latency_a: vld=%0b sel=%0b dat=%h in cycle n+4, required 1 0 26", iop_vld, iop_sel, iop_dat);
      end
      wait_drain();

      // Modular reduction and wrap-around
      send(64'd0, 64'h100000000, 64'h100000000, 1'b0, 1, 64'h00000000FFFFFFFF, 64'hFFFFFFFE00000002);
      send(Q - 64'd1, 64'd1, 64'd1, 1'b0, 1, 64'd0, 64'hFFFFFFFEFFFFFFFF);
      wait_drain();

      // Backpressure: 8 random triples, iop_rdy at ~30%
      duty = 30;
      for (int i = 0; i < 8; i++) begin
         logic dd;
`ifdef BPE_DIF_EN
         dd = 1'($urandom_range(0, 1));
`else
         dd = 1'b0;
`endif
         send(rand_coef(), rand_coef(), rand_coef(), dd, 0, 64'd0, 64'd0);
      end
      wait_drain();

      // Streaming: 100 triples with iop_rdy held high
      duty = 100;
      repeat (2) @(posedge clk);
      #1;
      in_stream = 1;
      for (int i = 0; i < 100; i++) begin
         logic dd;
`ifdef BPE_DIF_EN
         dd = 1'($urandom_range(0, 1));
`else
         dd = 1'b0;
`endif
         send(rand_coef(), rand_coef(), rand_coef(), dd, 0, 64'd0, 64'd0);
      end
      wait_drain();
      in_stream = 0;
      checks++;
      if (stream_beats != 200 || (stream_last - stream_first) != 199) begin
         errors++;
         $display("FAIL stream_gapless: %0d beats over %0d cycles, required 200 beats over 200 cycles",
                  stream_beats, stream_last - stream_first + 1);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || iop_vld !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle: busy=%0b vld=%0b after drain, required 0 0", busy, iop_vld);
      end
      @(posedge clk);
      #1;

      // Reset mid-operation with a stalled B' beat
      rdy_manual = 1'b1;
      duty = -1;
      @(posedge clk);
      #1;
      send(64'd1, 64'd2, 64'd3, 1'b0, 0, 64'd0, 64'd0);
      send(64'd4, 64'd5, 64'd6, 1'b0, 0, 64'd0, 64'd0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(iop_vld && !iop_sel) && t < 100);
      rdy_manual = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (iop_vld !== 1'b1 || iop_sel !== 1'b1) begin
         errors++;
         $display("FAIL stall_b: vld=%0b sel=%0b, required 1 1", iop_vld, iop_sel);
      end
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (iop_vld !== 1'b0 || busy !== 1'b0 || bpe_rdy !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset: vld=%0b busy=%0b rdy=%0b, required 0 0 0", iop_vld, busy, bpe_rdy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      duty = 100;
      @(posedge clk);
      #1;
      send(64'd5, 64'd3, 64'd7, 1'b0, 1, 64'd26, 64'hFFFFFFFEFFFFFFF1);
      wait_drain();
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL final_idle: %0d beats pending busy=%0b, required 0 0", sb.size(), busy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
